pong_state_uart_tx: RTL



---
 rtl/pong_state_uart_tx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pong_state_uart_tx.sv
// Snapshots the game state on each frame tick and streams it to the peer board
// as a 9-byte 8N1 UART packet: sync, ball x/y, paddle y, scores, XOR checksum.
module pong_state_uart_tx #(
    parameter int unsigned CLK_DIV   = 564,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        timing_tick,
    input  logic [10:0] x_ball,
    input  logic [9:0]  y_ball,
    input  logic [9:0]  y_player,
    input  logic [3:0]  player1_score,
    input  logic [3:0]  player2_score,
    output logic        tx,
    output logic        busy,
    output logic        pkt_done,
    output logic [7:0]  drop_cnt
);

    localparam logic [11:0] BaudLast = 12'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  byte_q, byte_d;
    logic [7:0]  drop_q, drop_d;
    logic        tx_q, tx_d;
    logic        snap_en;
    logic        baud_tc;

    logic [10:0] x_q;
    logic [9:0]  yb_q;
    logic [9:0]  yp_q;
    logic [3:0]  p1_q;
    logic [3:0]  p2_q;

    logic [7:0]  pkt_byte [9];
    logic [7:0]  checksum;
    logic [7:0]  next_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            yb_q <= '0;
            yp_q <= '0;
            p1_q <= '0;
            p2_q <= '0;
        end else if (snap_en) begin
            x_q  <= x_ball;
            yb_q <= y_ball;
            yp_q <= y_player;
            p1_q <= player1_score;
            p2_q <= player2_score;
        end
    end

    // The snapshot is frozen for the whole packet, so the checksum can stay combinational.
    always_comb begin
        pkt_byte[0] = SYNC_BYTE;
        pkt_byte[1] = {5'b0, x_q[10:8]};
        pkt_byte[2] = x_q[7:0];
        pkt_byte[3] = {6'b0, yb_q[9:8]};
        pkt_byte[4] = yb_q[7:0];
        pkt_byte[5] = {6'b0, yp_q[9:8]};
        pkt_byte[6] = yp_q[7:0];
        pkt_byte[7] = {p1_q, p2_q};
        checksum    = pkt_byte[1] ^ pkt_byte[2] ^ pkt_byte[3] ^ pkt_byte[4]
                    ^ pkt_byte[5] ^ pkt_byte[6] ^ pkt_byte[7];
        pkt_byte[8] = checksum;
    end

    assign baud_tc = (baud_q == BaudLast);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        snap_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (timing_tick && en) begin
                    snap_en = 1'b1;
                    state_d = StStart;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            StStart: begin
                baud_d = baud_tc ? 12'd0 : baud_q + 12'd1;
                if (baud_tc) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                baud_d = baud_tc ? 12'd0 : baud_q + 12'd1;
                if (baud_tc) begin
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                baud_d = baud_tc ? 12'd0 : baud_q + 12'd1;
                if (baud_tc) begin
                    if (byte_q == 4'd8) begin
                        state_d = StDone;
                    end else begin
                        byte_d  = byte_q + 4'd1;
                        state_d = StStart;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                byte_d  = '0;
                bit_d   = '0;
                baud_d  = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Ticks arriving in any non-idle state, DONE included, are dropped and counted.
    always_comb begin
        drop_d = drop_q;
        if (timing_tick && (state_q != StIdle) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // tx is registered from the next state so the pin never sees mux glitches.
    always_comb begin
        next_byte = (byte_d <= 4'd8) ? pkt_byte[byte_d] : 8'hFF;
        tx_d      = 1'b1;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = next_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            drop_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            drop_q  <= drop_d;
            tx_q    <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
    assign pkt_done = (state_q == StDone);
    assign drop_cnt = drop_q;

endmodule
